regfile_bypass_sb: RTL and testbench
====================================

// Module: regfile_bypass_sb
// PURPOSE
//   Parametrised register file for the ID/WB stages. It provides:
//   - N combinational read ports with same-cycle write bypass.
//   - One writeback port plus a dedicated link-register port for jal.
//   - A hardwired zero register.
//   - A pending-write scoreboard that flags hazards to the hazard unit.
//   - A registered debug read port.
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//   NRD       2   number of read ports (1..4)
//   ZERO_REG  1   1: entry 0 reads 0, ignores writes, is never marked busy
//   LINK_REG  31  index written by the link port
//   BYPASS    1   1: read ports forward same-cycle write data
// PORTS
//   clk        in   1             clock; all state updates on posedge
//   reset      in   1             reset, synchronous, active-high
//   rd_addr    in   NRD*ADDR_W    read addresses; port k is [k*ADDR_W +: ADDR_W]
//   rd_data    out  NRD*DATA_W    read data, combinational
//   rd_busy    out  NRD           1 = read register has an outstanding producer
//   wr_en      in   1             writeback enable
//   wr_addr    in   ADDR_W        writeback address
//   wr_data    in   DATA_W        writeback data
//   link_en    in   1             jal link write to LINK_REG
//   link_data  in   DATA_W        return address (PC+4)
//   issue_en   in   1             marks issue_addr as pending (producer issued)
//   issue_addr in   ADDR_W        destination of the issued instruction
//   dbg_addr   in   ADDR_W        debug read address
//   dbg_data   out  DATA_W        debug read data, registered
// BEHAVIOUR
//   - Reset: if reset=1 at posedge, the following take effect next cycle:
//       all entries = 0; all busy bits = 0; dbg_data = 0.
//     Reset overrides every write, issue and clear in that same cycle.
//     rd_data follows the cleared array (reads return 0, except bypassed data).
//   - Writes: committed at posedge; the new value is visible through the array
//     one cycle later.
//   - wr_en and link_en both target LINK_REG in the same cycle:
//     link_data is stored (link port wins).
//     Different targets: both writes commit.
//   - ZERO_REG=1:
//     - writes to addr 0 are dropped;
//     - rd_data for addr 0 = 0, even when bypassed;
//     - issue to addr 0 is ignored.
//   - Bypass (BYPASS=1): for each read port k, in priority order:
//       1. link_en and rd_addr[k]==LINK_REG         -> link_data
//       2. else wr_en and rd_addr[k]==wr_addr        -> wr_data
//       3. else                                      -> entry[rd_addr[k]]
//     BYPASS=0: read port returns the array value only (old value in the
//     write cycle).
//   - Read latency: 0 cycles for rd_data and rd_busy; 1 cycle for dbg_data.
//   - dbg_data <= entry[dbg_addr] each posedge.
//     dbg_data does not bypass the same-cycle write (shows the pre-write value).
//   - Scoreboard: one busy bit per entry, updated each posedge.
//     - set on issue_en to issue_addr;
//     - clear on wr_en to wr_addr; clear on link_en to LINK_REG;
//     - set and clear of the same entry in one cycle: set wins (new producer).
//   - rd_busy[k] = busy[rd_addr[k]] masked by any same-cycle clear of that
//     address, if BYPASS=1.
//     The hazard unit stalls on rd_busy; this block never stalls by itself.
//   - Address width: addresses are always in range (DEPTH = 2**ADDR_W), so
//     there is no out-of-range case.
//   - X on wr_en or issue_en outside reset is a bench error; assertion-checked.
// STRUCTURE
//   - Shared package regfile_pkg holds:
//       DATA_W and ADDR_W defaults, the LINK_REG constant (31),
//       and the ZERO_IDX constant (0).
//   - Sub-module regfile_scoreboard, parameters ADDR_W and ZERO_REG:
//       busy vector, set/clear priority, masked busy lookup per read port.
//   - Top level: storage array, bypass muxes, debug register.
//     Read ports are built by a generate loop over NRD.
// TESTING
//   1. Reset: write 0xDEADBEEF to r5, assert reset 1 cycle.
//      -> r5 reads 0, all rd_busy=0, dbg_data=0.
//   2. Bypass: wr_en, wr_addr=7, wr_data=0x1234, rd_addr0=7 in the same cycle.
//      -> rd_data0=0x1234 combinationally; 0x1234 on the next cycle from the array.
//   3. Link collision: wr_en r31=0xAAAA and link_en link_data=0x0040 together.
//      -> r31=0x0040; rd_busy for 31 cleared.
//   4. Zero reg: write 0xFFFF to r0, issue r0.
//      -> r0 reads 0; rd_busy for r0 stays 0.
//   5. Scoreboard: issue r9, then 3 idle cycles, then wr r9.
//      -> rd_busy=1 during the idle cycles.
//      -> rd_busy=0 in the write cycle (masked) and after it.
//      Also: issue r9 and wr r9 in the same cycle -> busy stays 1.
//   6. Debug and reset mid-op: dbg_addr=3 after writing r3=0x55.
//      -> dbg_data=0x55 one cycle later.
//      Reset asserted together with wr r3=0x77 -> r3=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the ID/WB register file slice.
//   DATA_W_DEF : default register width in bits
//   ADDR_W_DEF : default address width (DEPTH = 2**ADDR_W)
//   LINK_REG   : entry written by the jal link port
//   ZERO_IDX   : index of the hardwired zero register
// The helper isZeroAddr() lets the top and the scoreboard agree on what
// counts as the zero register for a given address width.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int LINK_REG   = 31;
    localparam int ZERO_IDX   = 0;

    // True when 'addr' hits the zero register and the zero register is enabled.
    function automatic logic isZeroAddr(input int addr, input int zeroReg);
        return (zeroReg != 0) && (addr == ZERO_IDX);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Pending-write scoreboard: one busy bit per register entry.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   issue_en/addr     producer issued: marks issue_addr busy
//   wr_en/wr_addr     writeback: clears wr_addr
//   link_en           link write: clears LINK_REG
//   rd_addr           NRD packed read addresses
//   rd_busy           per-read-port busy flag (masked by same-cycle clears
//                     when BYPASS=1, since the data is forwarded anyway)
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int NRD      = 2,
    parameter int LINK_IDX = LINK_REG,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_en,
    input  logic [ADDR_W-1:0]     issue_addr,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic                  link_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0]        rd_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busyNext;

    // Clears are applied first so that a set to the same entry wins:
    // the newly issued producer supersedes the one completing now.
    always_comb begin
        w_busyNext = r_busy;
        if (wr_en)
            w_busyNext[wr_addr] = 1'b0;
        if (link_en)
            w_busyNext[LINK_A] = 1'b0;
        if (issue_en && !isZeroAddr(int'(issue_addr), ZERO_REG))
            w_busyNext[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_busy <= '0;
        else
            r_busy <= w_busyNext;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_busyPort
        logic [ADDR_W-1:0] w_addr;
        logic              w_clrHit;

        assign w_addr   = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_clrHit = (wr_en && (w_addr == wr_addr)) ||
                          (link_en && (w_addr == LINK_A));
        assign rd_busy[k] = r_busy[w_addr] & ~((BYPASS != 0) & w_clrHit);
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// -----------------------------------------------------------------------------
// regfile_bypass_sb
// Register file for the ID/WB stages with same-cycle write bypass, a jal
// link port, hardwired zero register, pending-write scoreboard and a
// registered debug read port.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   rd_addr / rd_data     NRD combinational read ports (packed, port k at k*W)
//   rd_busy               per-port outstanding-producer flag
//   wr_en/addr/data       writeback port
//   link_en/link_data     link write to LINK_REG (wins over writeback)
//   issue_en/issue_addr   marks a destination as pending
//   dbg_addr / dbg_data   debug read, one cycle latency, no bypass
// -----------------------------------------------------------------------------
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int LINK_IDX = LINK_REG,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  link_en,
    input  logic [DATA_W-1:0]     link_data,
    input  logic                  issue_en,
    input  logic [ADDR_W-1:0]     issue_addr,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dbgData;

    // Storage update. The link write comes last so it wins a collision on
    // LINK_REG; writes aimed at the zero register are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (wr_en && !isZeroAddr(int'(wr_addr), ZERO_REG))
                r_mem[wr_addr] <= wr_data;
            if (link_en && !isZeroAddr(LINK_IDX, ZERO_REG))
                r_mem[LINK_A] <= link_data;
        end
    end

    // Debug read samples the array before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (reset)
            r_dbgData <= '0;
        else
            r_dbgData <= r_mem[dbg_addr];
    end

    assign dbg_data = r_dbgData;

    for (genvar k = 0; k < NRD; k++) begin : g_readPort
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_val;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        // Link bypass has priority over writeback bypass, matching which
        // value the array will hold after the collision.
        always_comb begin
            w_val = r_mem[w_addr];
            if (BYPASS != 0) begin
                if (link_en && (w_addr == LINK_A))
                    w_val = link_data;
                else if (wr_en && (w_addr == wr_addr))
                    w_val = wr_data;
            end
            if (isZeroAddr(int'(w_addr), ZERO_REG))
                w_val = '0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_val;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .NRD      (NRD),
        .LINK_IDX (LINK_IDX),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .link_en    (link_en),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy)
    );

    // Enables must be known whenever the block is out of reset.
    a_enKnown : assert property (@(posedge clk) disable iff (reset)
        !$isunknown({wr_en, issue_en}));

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_bypass_sb
// Directed bench for regfile_bypass_sb (defaults: 32-bit, 32 entries, 2 read
// ports, zero register, link register 31, bypass on). Inputs change 1 time
// unit after the rising edge; outputs are checked 1 time unit after inputs
// settle, well away from the edge.
// -----------------------------------------------------------------------------
module tb_regfile_bypass_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic           clk;
    logic           reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic           link_en;
    logic [DW-1:0]  link_data;
    logic           issue_en;
    logic [AW-1:0]  issue_addr;
    logic [AW-1:0]  dbg_addr;
    logic [DW-1:0]  dbg_data;

    int assertCount = 0;
    int failCount   = 0;

    regfile_bypass_sb dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .link_en    (link_en),
        .link_data  (link_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives the write/link/issue controls for the coming edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic le,
                                 input logic [DW-1:0] ld, input logic ie,
                                 input logic [AW-1:0] ia);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        link_en    = le;
        link_data  = ld;
        issue_en   = ie;
        issue_addr = ia;
    endtask

    task automatic setRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Port-0 / port-1 views of the packed read outputs
    function automatic logic [DW-1:0] rd0();
        return rd_data[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rd1();
        return rd_data[2*DW-1:DW];
    endfunction

    initial begin
        reset    = 1'b1;
        dbg_addr = '0;
        setRead(5'd0, 5'd0);
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset: populate r5, mark r6 busy, then reset while debug points at r5
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b1, 5'd6);
        tick();
        idle();
        setRead(5'd5, 5'd6);
        #1;
        checkOutput("r5 written", rd0(), 32'hDEADBEEF);
        checkOutput("r6 busy before reset", {31'd0, rd_busy[1]}, 32'd1);
        reset    = 1'b1;
        dbg_addr = 5'd5;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("r5 after reset", rd0(), 32'd0);
        checkOutput("busy after reset", {30'd0, rd_busy}, 32'd0);
        checkOutput("dbg after reset", dbg_data, 32'd0);

        // Bypass: same-cycle write forwarded, then visible from the array
        applyStimulus(1'b1, 5'd7, 32'h1234, 1'b0, '0, 1'b0, '0);
        setRead(5'd7, 5'd8);
        #1;
        checkOutput("bypass r7", rd0(), 32'h1234);
        checkOutput("no bypass r8", rd1(), 32'd0);
        tick();
        idle();
        #1;
        checkOutput("array r7", rd0(), 32'h1234);

        // Link collision on r31 after r31 was issued
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd31);
        tick();
        idle();
        setRead(5'd7, 5'd31);
        #1;
        checkOutput("r31 busy", {31'd0, rd_busy[1]}, 32'd1);
        applyStimulus(1'b1, 5'd31, 32'hAAAA, 1'b1, 32'h0040, 1'b0, '0);
        #1;
        checkOutput("link bypass r31", rd1(), 32'h0040);
        checkOutput("r31 busy masked", {31'd0, rd_busy[1]}, 32'd0);
        tick();
        idle();
        #1;
        checkOutput("array r31", rd1(), 32'h0040);
        checkOutput("r31 busy cleared", {31'd0, rd_busy[1]}, 32'd0);

        // Zero register: write and issue to r0 are ignored
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, 1'b1, 5'd0);
        setRead(5'd0, 5'd7);
        #1;
        checkOutput("r0 bypass", rd0(), 32'd0);
        tick();
        idle();
        #1;
        checkOutput("r0 array", rd0(), 32'd0);
        checkOutput("r0 busy", {31'd0, rd_busy[0]}, 32'd0);

        // Scoreboard: issue r9, three idle cycles, then writeback
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd9);
        setRead(5'd9, 5'd7);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("r9 busy idle%0d", i), {31'd0, rd_busy[0]}, 32'd1);
            tick();
        end
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, '0, 1'b0, '0);
        #1;
        checkOutput("r9 busy masked", {31'd0, rd_busy[0]}, 32'd0);
        tick();
        idle();
        #1;
        checkOutput("r9 busy after wr", {31'd0, rd_busy[0]}, 32'd0);
        checkOutput("r9 data", rd0(), 32'h99);
        // Set and clear in the same cycle: the new producer wins
        applyStimulus(1'b1, 5'd9, 32'h9A, 1'b0, '0, 1'b1, 5'd9);
        tick();
        idle();
        #1;
        checkOutput("r9 busy set wins", {31'd0, rd_busy[0]}, 32'd1);
        checkOutput("r9 data 9A", rd0(), 32'h9A);
        tick();
        #1;
        checkOutput("r9 busy holds", {31'd0, rd_busy[0]}, 32'd1);

        // Debug port: one-cycle latency, shows the pre-write value
        applyStimulus(1'b1, 5'd3, 32'h55, 1'b0, '0, 1'b0, '0);
        tick();
        idle();
        dbg_addr = 5'd3;
        tick();
        checkOutput("dbg r3", dbg_data, 32'h55);
        applyStimulus(1'b1, 5'd3, 32'h66, 1'b0, '0, 1'b0, '0);
        tick();
        idle();
        checkOutput("dbg pre-write", dbg_data, 32'h55);
        tick();
        checkOutput("dbg post-write", dbg_data, 32'h66);

        // Reset overrides a same-cycle write
        applyStimulus(1'b1, 5'd3, 32'h77, 1'b0, '0, 1'b0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        setRead(5'd3, 5'd9);
        #1;
        checkOutput("r3 after reset", rd0(), 32'd0);
        checkOutput("dbg reset mid-op", dbg_data, 32'd0);
        checkOutput("r9 busy reset", {31'd0, rd_busy[1]}, 32'd0);
        tick();
        checkOutput("dbg r3 zero", dbg_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
